inj_sched: RTL and testbench
============================

Name: inj_sched

Overview:
- Injection scheduler that sequences N traffic-source ROM buffers onto one shared 20-bit injection link.
- Each source has an enable input and, one cycle later, a registered `valid`/`data` output. The source holds its position while enable is low.
- The block grants sources round-robin with a fixed enable quota per grant and retires sources that stop producing.
- Returned flits are absorbed in a small skid FIFO and forwarded to the router injection port with a valid/ready handshake.

Parameters:
- N, 4, number of sources (2..8).
- QUANTUM, 8, enable cycles issued per grant (1..255).
- IDLE_LIMIT, 3, consecutive silent enable cycles that mark a source exhausted (1..15).
- FIFO_DEPTH, 4, skid FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse; begins a scheduling run.
- src_data  in  N*20  source words; source i on bits [20i+19:20i].
- src_valid  in  N  source out_valid flags.
- src_en  out  N  per-source enable, one-hot or zero.
- link_data  out  20  flit to router (payload[19:4], dest_cluster[3:2], dest_local[1:0]).
- link_valid  out  1  FIFO non-empty.
- link_ready  in  1  router accepts flit.
- busy  out  1  run in progress (state not IDLE/DONE, or FIFO non-empty).
- all_done  out  1  every source retired and FIFO empty.
- flit_count  out  16  link handshakes this run, saturating.

Behaviour:
- Reset: async, active-low. All registers clear immediately: src_en=0, link_valid=0, link_data=0, busy=0, all_done=0, flit_count=0, live mask=0, FIFO empty, state IDLE. Reset mid-run abandons in-flight flits.
- States: IDLE, SELECT, GRANT, DRAIN, DONE.
- IDLE/DONE, on start=1:
  - live mask set to all ones, ptr=0, flit_count=0, all_done=0.
  - Next state SELECT.
  - start in any other state is ignored.
- SELECT (1 cycle):
  - gnt = first index with live=1 searching ptr, ptr+1, … mod N.
  - If none is live → DONE.
  - Otherwise load quota=QUANTUM and silent=0 → GRANT.
- GRANT:
  - src_en[gnt] = (fifo_count + inflight) < FIFO_DEPTH, where inflight = src_en registered from the previous cycle.
  - Each asserted enable cycle decrements quota.
  - When quota reaches 0 after an issue → DRAIN.
- Capture:
  - Any cycle with src_valid[gnt]=1 and prev-cycle src_en[gnt]=1 pushes src_data[gnt] into the FIFO. The FIFO cannot overflow by construction.
  - src_valid from non-granted sources is ignored.
- Exhaustion:
  - A cycle with prev-cycle src_en[gnt]=1 and src_valid[gnt]=0 increments silent; a valid resets silent to 0.
  - When silent reaches IDLE_LIMIT: clear live[gnt] → DRAIN.
  - The source's first-ever enable yields no valid (activation cycle), so the first grant delivers at most QUANTUM-1 flits.
- DRAIN (1 cycle):
  - src_en=0; the last in-flight valid is still captured.
  - ptr=(gnt+1) mod N → SELECT.
- DONE: src_en=0. all_done=1 once the FIFO is empty; held until the next start.
- Link:
  - link_valid = FIFO non-empty; pop on link_valid & link_ready.
  - link_data is held stable while valid & !ready.
  - Push and pop in the same cycle are allowed when the FIFO is full.
  - flit_count increments per pop and saturates at 16'hFFFF.
- Latency: source valid → link_valid is 1 cycle when the FIFO is empty.

Optional Feature:
- Macro INJ_SCHED_SRC_STATS_EN.
- Defined: adds output src_flit_cnt (N*8 bits). Per-source count of flits pushed, saturating at 8'hFF, cleared on start and reset.
- Undefined: port absent, no counters; all other behaviour identical.

Test Plan:
- Reset then start, N=4, each source a 30-word ROM stream, link_ready=1 → src_en sequence 0,1,2,3,0,…. Grant 1 per source delivers 7 flits, later grants 8. After 120 flits all_done=1 and flit_count=120.
- Source 2 has 0 words → source 2 is retired after 3 silent enables. Sources 0,1,3 each deliver 30 flits; flit_count=90.
- link_ready held 0 for 20 cycles mid-grant → FIFO fills to 4, src_en drops to 0, no flit is lost or duplicated. Order is preserved after release.
- Async rst low mid-GRANT → src_en, link_valid and flit_count all 0 immediately. A later start restarts from source 0.
- start pulsed during GRANT → ignored; grant sequence unchanged.
- INJ_SCHED_SRC_STATS_EN defined, scenario 1 → src_flit_cnt reads 30 for each of the 4 sources.

Source files
------------

// File: rtl/inj_sched.sv
// inj_sched: round-robin injection scheduler that sequences N source ROMs onto one 20-bit link via a skid FIFO.
// Optional per-source push counters (src_flit_cnt) are built when INJ_SCHED_SRC_STATS_EN is defined.
module inj_sched #(
  parameter int N          = 4,
  parameter int QUANTUM    = 8,
  parameter int IDLE_LIMIT = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N*20-1:0] src_data,
  input  logic [N-1:0]    src_valid,
  output logic [N-1:0]    src_en,
  output logic [19:0]     link_data,
  output logic            link_valid,
  input  logic            link_ready,
  output logic            busy,
  output logic            all_done,
  output logic [15:0]     flit_count
`ifdef INJ_SCHED_SRC_STATS_EN
  ,
  output logic [N*8-1:0]  src_flit_cnt
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [7:0]    QuotaInit = 8'(QUANTUM);
  localparam logic [4:0]    SilentMax = 5'(IDLE_LIMIT);
  localparam logic [CW:0]   DepthCmp  = (CW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] LastIdx   = IW'(N-1);

  typedef enum logic [2:0] {IDLE, SELECT, GRANT, DRAIN, DONE} state_e;

  state_e        state_q;
  logic [N-1:0]  live_q;
  logic [N-1:0]  inflight_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] gnt_q;
  logic [7:0]    quota_q;
  logic [3:0]    silent_q;
  logic [3:0]    silent_d;
  logic [19:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [15:0]   flit_count_q;

  logic          idle_like;
  logic          start_acc;
  logic          prev_en;
  logic          push;
  logic          pop;
  logic          exhaust;
  logic          grant_ok;
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [CW:0]   occupancy;
  logic [19:0]   gnt_data;

  // Round-robin search: first live source at or after ptr, wrapping modulo N.
  function automatic logic [IW:0] pick_next(input logic [N-1:0] live, input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (live[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  assign {sel_found, sel_idx} = pick_next(live_q, ptr_q);

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign start_acc = start && idle_like;
  assign prev_en   = inflight_q[gnt_q];
  assign gnt_data  = src_data[int'(gnt_q)*20 +: 20];
  assign push      = prev_en && src_valid[gnt_q];
  assign pop       = (count_q != '0) && link_ready;

  // An enable is only issued when the FIFO can still absorb it plus any word already in flight.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, |inflight_q};
  assign grant_ok  = (state_q == GRANT) && (occupancy < DepthCmp);

  always_comb begin
    src_en = '0;
    if (grant_ok) src_en[gnt_q] = 1'b1;
  end

  always_comb begin
    silent_d = silent_q;
    exhaust  = 1'b0;
    if (push) begin
      silent_d = '0;
    end else if (prev_en) begin
      if (silent_q != 4'hF) silent_d = silent_q + 4'd1;
      exhaust = ({1'b0, silent_q} + 5'd1) >= SilentMax;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      live_q     <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      quota_q    <= '0;
      silent_q   <= '0;
      inflight_q <= '0;
    end else begin
      inflight_q <= src_en;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            live_q  <= '1;
            ptr_q   <= '0;
            state_q <= SELECT;
          end
        end
        SELECT: begin
          if (!sel_found) begin
            state_q <= DONE;
          end else begin
            gnt_q    <= sel_idx;
            quota_q  <= QuotaInit;
            silent_q <= '0;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          silent_q <= silent_d;
          if (grant_ok) quota_q <= quota_q - 8'd1;
          if (exhaust) live_q[gnt_q] <= 1'b0;
          if (exhaust || (grant_ok && quota_q == 8'd1)) state_q <= DRAIN;
        end
        DRAIN: begin
          // The final enable of the grant still lands here, so it can also retire the source.
          silent_q <= silent_d;
          if (exhaust) live_q[gnt_q] <= 1'b0;
          ptr_q   <= (gnt_q == LastIdx) ? '0 : gnt_q + IW'(1);
          state_q <= SELECT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      flit_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= gnt_data;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
      if (start_acc) flit_count_q <= '0;
      else if (pop && flit_count_q != 16'hFFFF) flit_count_q <= flit_count_q + 16'd1;
    end
  end

  assign link_data  = mem_q[rptr_q];
  assign link_valid = (count_q != '0);
  assign flit_count = flit_count_q;
  assign busy       = !idle_like || (count_q != '0);
  assign all_done   = (state_q == DONE) && (count_q == '0);

`ifdef INJ_SCHED_SRC_STATS_EN
  logic [7:0] stat_q [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (start_acc) stat_q[i] <= '0;
        else if (push && gnt_q == IW'(i) && stat_q[i] != 8'hFF) stat_q[i] <= stat_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    src_flit_cnt = '0;
    for (int i = 0; i < N; i++) src_flit_cnt[i*8 +: 8] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_inj_sched.sv
// tb_inj_sched: scoreboard bench for inj_sched with behavioural ROM sources (activation cycle, hold while disabled).
// Define INJ_SCHED_SRC_STATS_EN to also exercise the per-source push counters.
module tb_inj_sched;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [N*20-1:0] srcData = '0;
  logic [N-1:0]    srcValid = '0;
  logic [N-1:0]    srcEn;
  logic [19:0]     linkData;
  logic            linkValid;
  logic            linkReady = 1'b1;
  logic            busy;
  logic            allDone;
  logic [15:0]     flitCount;
`ifdef INJ_SCHED_SRC_STATS_EN
  logic [N*8-1:0]  srcFlitCnt;
`endif

  always #5 clk = ~clk;

  inj_sched #(.N(N), .QUANTUM(8), .IDLE_LIMIT(3), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_data   (srcData),
    .src_valid  (srcValid),
    .src_en     (srcEn),
    .link_data  (linkData),
    .link_valid (linkValid),
    .link_ready (linkReady),
    .busy       (busy),
    .all_done   (allDone),
`ifdef INJ_SCHED_SRC_STATS_EN
    .src_flit_cnt (srcFlitCnt),
`endif
    .flit_count (flitCount)
  );

  int          srcLen [N];
  int          srcPos [N];
  bit          srcAct [N];
  logic [N-1:0] enSample;
  logic [19:0] expQ [$];
  int          gList [$];
  int          pList [$];
  int          lastIdx = -1;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [19:0] mkWord(input int s, input int p);
    return {4'(s), 12'(p), 4'(p + s)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModels(input int l0, input int l1, input int l2, input int l3);
    srcLen[0] = l0; srcLen[1] = l1; srcLen[2] = l2; srcLen[3] = l3;
    for (int i = 0; i < N; i++) begin
      srcPos[i] = 0;
      srcAct[i] = 1'b0;
    end
    srcValid = '0;
    expQ.delete();
    gList.delete();
    pList.delete();
    lastIdx = -1;
  endtask

  // Negedge: record grant order, pop the scoreboard on each link handshake.
  task automatic monitorStep();
    int idx;
    enSample = srcEn;
    if (rst) begin
      checkOutput("srcEnOneHot", 32'($onehot0(srcEn)), 32'd1);
      if (srcEn != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (srcEn[i]) idx = i;
        if (idx != lastIdx) begin
          if (lastIdx >= 0) pList.push_back(srcPos[lastIdx]);
          gList.push_back(idx);
          lastIdx = idx;
        end
      end
      if (linkValid && linkReady) begin
        if (expQ.size() == 0) checkOutput("flitUnexpected", 32'd1, 32'd0);
        else checkOutput("flitData", 32'(linkData), 32'(expQ.pop_front()));
      end
    end
  endtask

  // Just after posedge: each ROM answers the enable it saw in the previous cycle.
  task automatic sourceStep();
    for (int i = 0; i < N; i++) begin
      srcValid[i] = 1'b0;
      if (enSample[i]) begin
        if (!srcAct[i]) begin
          srcAct[i] = 1'b1;
        end else if (srcPos[i] < srcLen[i]) begin
          srcValid[i] = 1'b1;
          srcData[i*20 +: 20] = mkWord(i, srcPos[i]);
          expQ.push_back(mkWord(i, srcPos[i]));
          srcPos[i]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitorStep();
    @(posedge clk);
    #1;
    sourceStep();
    #1;
  endtask

  // mode 0: start pulse mid-grant, 1: link stall, 2: reset abort, 3: plain run
  task automatic applyStimulus(input int mode, input int budget);
    int n = 0;
    bit latDone = 0;
    bit evDone = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!allDone && n < budget) begin
      if (!latDone && srcValid != '0) begin
        latDone = 1;
        checkOutput("latEmpty", 32'(linkValid), 32'd0);
        checkOutput("busyRun", 32'(busy), 32'd1);
        tick(); n++;
        checkOutput("latValid", 32'(linkValid), 32'd1);
        if (expQ.size() == 0) checkOutput("latQueue", 32'd0, 32'd1);
        else checkOutput("latData", 32'(linkData), 32'(expQ[0]));
      end
      if (!evDone && gList.size() == 2 && srcEn != '0) begin
        evDone = 1;
        if (mode == 0) begin
          start = 1'b1;
          tick(); n++;
          start = 1'b0;
        end else if (mode == 1) begin
          linkReady = 1'b0;
          repeat (20) begin tick(); n++; end
          checkOutput("stallEnOff", 32'(srcEn), 32'd0);
          checkOutput("stallValid", 32'(linkValid), 32'd1);
          checkOutput("stallFill", 32'(expQ.size()), 32'd4);
          linkReady = 1'b1;
        end else if (mode == 2) begin
          checkOutput("preRstCount", 32'(flitCount != 0), 32'd1);
          rst = 1'b0;
          #1;
          checkOutput("rstSrcEn", 32'(srcEn), 32'd0);
          checkOutput("rstLinkValid", 32'(linkValid), 32'd0);
          checkOutput("rstFlitCount", 32'(flitCount), 32'd0);
          checkOutput("rstBusy", 32'(busy), 32'd0);
          return;
        end
      end
      tick(); n++;
    end
    if (mode == 2) checkOutput("rstReached", 32'(evDone), 32'd1);
    if (!allDone) checkOutput("runTimeout", 32'd0, 32'd1);
  endtask

  task automatic checkOutput4Round(input int total);
    checkOutput("allDone", 32'(allDone), 32'd1);
    checkOutput("flitCount", 32'(flitCount), 32'(total));
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("busyIdle", 32'(busy), 32'd0);
    for (int k = 0; k < 8; k++) checkOutput("grantOrder", 32'(gList[k]), 32'(k % 4));
    for (int k = 0; k < 7; k++) checkOutput("grantFlits", 32'(pList[k]), (k < 4) ? 32'd7 : 32'd15);
  endtask

  initial begin
    #1;
    checkOutput("resetSrcEn", 32'(srcEn), 32'd0);
    checkOutput("resetLinkValid", 32'(linkValid), 32'd0);
    checkOutput("resetLinkData", 32'(linkData), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetAllDone", 32'(allDone), 32'd0);
    checkOutput("resetFlitCount", 32'(flitCount), 32'd0);
    #20;
    rst = 1'b1;
    tick();

    $display("[TB] scenario: four 30-word sources, start pulse during grant");
    resetModels(30, 30, 30, 30);
    applyStimulus(0, 3000);
    checkOutput4Round(120);
`ifdef INJ_SCHED_SRC_STATS_EN
    for (int i = 0; i < N; i++) checkOutput("srcFlitCnt", 32'(srcFlitCnt[i*8 +: 8]), 32'd30);
`endif

    $display("[TB] scenario: source 2 empty");
    resetModels(30, 30, 0, 30);
    applyStimulus(3, 3000);
    checkOutput("allDoneEmpty2", 32'(allDone), 32'd1);
    checkOutput("flitCountEmpty2", 32'(flitCount), 32'd90);
    checkOutput("queueEmpty2", 32'(expQ.size()), 32'd0);
    checkOutput("src2Flits", 32'(srcPos[2]), 32'd0);
    checkOutput("order4", 32'(gList[4]), 32'd0);
    checkOutput("order5", 32'(gList[5]), 32'd1);
    checkOutput("order6", 32'(gList[6]), 32'd3);

    $display("[TB] scenario: link stall mid-grant");
    resetModels(30, 30, 30, 30);
    applyStimulus(1, 3000);
    checkOutput4Round(120);

    $display("[TB] scenario: reset mid-grant then restart");
    resetModels(30, 30, 30, 30);
    applyStimulus(2, 3000);
    tick();
    tick();
    resetModels(30, 30, 30, 30);
    rst = 1'b1;
    tick();
    applyStimulus(3, 3000);
    checkOutput("restartFirst", 32'(gList[0]), 32'd0);
    checkOutput4Round(120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
